// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm/buzzer block: FSM state codes, default timing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alarm_pkg;

    // Sequencer state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TONE = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Default timing at a 50 MHz clock: 2 kHz tone, 100 ms beeps and gaps
    localparam int TONE_HALF_DEF = 12500;
    localparam int BEEP_CYC_DEF  = 5000000;
    localparam int GAP_CYC_DEF   = 5000000;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: output starts high on restart and toggles every half_m1+1 cycles.
// Latency: wave is registered; it reflects en/restart on the cycle after they are applied.
// Backpressure: none; free-running while enabled, forced low when disabled.
// Ports: clk, rst (sync, active-high), en (tone allowed next cycle), restart (begin a new
//        tone high phase), half_m1 (half-period length minus one), wave (square wave out).
module tone_gen #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic [CNT_W-1:0] half_m1,
    output logic             wave
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            wave <= 1'b0;
            cnt  <= '0;
        end else if (restart) begin
            wave <= 1'b1;
            cnt  <= '0;
        end else if (cnt == half_m1) begin
            // half period complete: flip and restart the count
            wave <= ~wave;
            cnt  <= '0;
        end else begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/buzzer_driver.sv
// Beep sequencer: plays `beeps` tone bursts separated by silent gaps, with stop/abort.
// Latency: trig sampled at edge T gives TONE (buzz=1, busy=1) at T+1; done is a registered pulse.
// Backpressure: none; trigs while busy are dropped, or held in a one-deep slot when
//               BUZZER_PENDING_EN is defined (newest request wins).
// Ports: clk, rst (sync, active-high), trig (request pulse), beeps (count, 0 = ignore),
//        stop (abort playback), buzz (square-wave drive), busy (sequence playing),
//        done (one-cycle pulse on completion or abort).
module buzzer_driver
    import alarm_pkg::*;
#(
    parameter int TONE_HALF = TONE_HALF_DEF,
    parameter int BEEP_CYC  = BEEP_CYC_DEF,
    parameter int GAP_CYC   = GAP_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [2:0] beeps,
    input  logic       stop,
    output logic       buzz,
    output logic       busy,
    output logic       done
);

    localparam int TW      = cnt_w(TONE_HALF);
    localparam int DUR_MAX = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
    localparam int DW      = cnt_w(DUR_MAX);

    logic [1:0]    state, state_nx;
    logic [DW-1:0] dur;
    logic [2:0]    rem;
    logic          pend_vld;
    logic [2:0]    pend_beeps;
    logic          req, abort, tone_end, gap_end, launch, restart, tone_en;

    // stop beats a simultaneous trig regardless of state
    assign req      = trig && !stop && (beeps != 3'd0);
    assign abort    = stop && (state != ST_IDLE);
    assign tone_end = (state == ST_TONE) && (dur == DW'(BEEP_CYC - 1));
    assign gap_end  = (state == ST_GAP)  && (dur == DW'(GAP_CYC - 1));
    // a new sequence starts from IDLE, either from a live trig or the held request
    assign launch   = (state == ST_IDLE) && (req || pend_vld);

    always_comb begin
        state_nx = state;
        restart  = 1'b0;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (launch) begin
                    state_nx = ST_TONE;
                    restart  = 1'b1;
                end
                ST_TONE: if (tone_end) begin
                    state_nx = (rem != 3'd0) ? ST_GAP : ST_IDLE;
                end
                ST_GAP: if (gap_end) begin
                    state_nx = ST_TONE;
                    restart  = 1'b1;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    assign tone_en = (state_nx == ST_TONE);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            dur   <= '0;
            rem   <= 3'd0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= abort || (tone_end && (rem == 3'd0));
            // duration restarts on every state change; cleared before it can wrap
            if ((state_nx != state) || (state_nx == ST_IDLE))
                dur <= '0;
            else
                dur <= dur + DW'(1);
            if (abort)
                rem <= 3'd0;
            else if (launch)
                rem <= (req ? beeps : pend_beeps) - 3'd1;
            else if (tone_end && (rem != 3'd0))
                rem <= rem - 3'd1;
        end
    end

`ifdef BUZZER_PENDING_EN
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            pend_vld   <= 1'b0;
            pend_beeps <= 3'd0;
        end else if (launch) begin
            // a launching trig supersedes any held request
            pend_vld   <= 1'b0;
            pend_beeps <= 3'd0;
        end else if (req && busy) begin
            pend_vld   <= 1'b1;
            pend_beeps <= beeps;
        end
    end
`else
    assign pend_vld   = 1'b0;
    assign pend_beeps = 3'd0;
`endif

    tone_gen #(
        .CNT_W (TW)
    ) u_tone_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (tone_en),
        .restart (restart),
        .half_m1 (TW'(TONE_HALF - 1)),
        .wave    (buzz)
    );

endmodule

// File: tb/tb_buzzer_driver.sv
// Directed bench for buzzer_driver with TONE_HALF=2, BEEP_CYC=8, GAP_CYC=4.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: n/a.
module tb_buzzer_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [2:0] beeps;
    logic       stop;
    logic       buzz;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    buzzer_driver #(
        .TONE_HALF (2),
        .BEEP_CYC  (8),
        .GAP_CYC   (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .trig  (trig),
        .beeps (beeps),
        .stop  (stop),
        .buzz  (buzz),
        .busy  (busy),
        .done  (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d got=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // expected buzz inside a tone that began at cycle s: high for 2, low for 2, ...
    function automatic logic tone_bit(input int c, input int s);
        return (((c - s) / 2) % 2) == 0;
    endfunction

    initial begin
        logic [7:0] pat;
        int         ndone;
        int         done_at;
        logic       eb;

        rst = 1'b1; trig = 1'b0; beeps = 3'd0; stop = 1'b0;
        tick(); tick();
        chk("rst_buzz", 0, buzz, 1'b0);
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_done", 0, done, 1'b0);
        rst = 1'b0;
        tick();

        // single beep: buzz 1,1,0,0,1,1,0,0 over cycles 1-8, done at 9
        pat = 8'b0011_0011;
        trig = 1'b1; beeps = 3'd1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            trig = 1'b0;
            chk("b1_buzz", c, buzz, (c <= 8) ? pat[c-1] : 1'b0);
            chk("b1_busy", c, busy, (c <= 8));
            chk("b1_done", c, done, (c == 9));
        end

        // three beeps: tone 1-8, gap 9-12, tone 13-20, gap 21-24, tone 25-32, done 33
        trig = 1'b1; beeps = 3'd3;
        ndone = 0; done_at = -1;
        for (int c = 1; c <= 36; c++) begin
            tick();
            trig = 1'b0;
            if (c >= 1 && c <= 8)        eb = tone_bit(c, 1);
            else if (c >= 13 && c <= 20) eb = tone_bit(c, 13);
            else if (c >= 25 && c <= 32) eb = tone_bit(c, 25);
            else                         eb = 1'b0;
            chk("b3_buzz", c, buzz, eb);
            chk("b3_busy", c, busy, (c <= 32));
            if (done) begin
                ndone++;
                done_at = c;
            end
        end
        chk_int("b3_done_count", ndone, 1);
        chk_int("b3_done_cycle", done_at, 33);

        // stop at cycle 5 of a two-beep sequence
        trig = 1'b1; beeps = 3'd2;
        for (int c = 1; c <= 5; c++) begin
            tick();
            trig = 1'b0;
            chk("stop_pre_busy", c, busy, 1'b1);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_buzz", 6, buzz, 1'b0);
        chk("stop_busy", 6, busy, 1'b0);
        chk("stop_done", 6, done, 1'b1);
        for (int c = 7; c <= 20; c++) begin
            tick();
            chk("stop_after_busy", c, busy, 1'b0);
            chk("stop_after_buzz", c, buzz, 1'b0);
            chk("stop_after_done", c, done, 1'b0);
        end

        // second request arriving at cycle 3 while the first plays
        trig = 1'b1; beeps = 3'd1;
        ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            trig = (c == 3);
            chk("pend_done", c, done, (c == 9)
`ifdef BUZZER_PENDING_EN
                || (c == 18)
`endif
            );
`ifdef BUZZER_PENDING_EN
            chk("pend_busy", c, busy, (c <= 8) || (c >= 10 && c <= 17));
            chk("pend_buzz", c, buzz, (c <= 8) ? tone_bit(c, 1) :
                                     (c >= 10 && c <= 17) ? tone_bit(c, 10) : 1'b0);
`else
            chk("pend_busy", c, busy, (c <= 8));
            chk("pend_buzz", c, buzz, (c <= 8) ? tone_bit(c, 1) : 1'b0);
`endif
        end
        trig = 1'b0;

        // reset at cycle 4 mid-tone: silent at 5, no done afterwards
        trig = 1'b1; beeps = 3'd1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            trig = 1'b0;
        end
        chk("rst_mid_pre_busy", 4, busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_buzz", 5, buzz, 1'b0);
        chk("rst_mid_busy", 5, busy, 1'b0);
        chk("rst_mid_done", 5, done, 1'b0);
        for (int c = 6; c <= 14; c++) begin
            tick();
            chk("rst_mid_after_done", c, done, 1'b0);
            chk("rst_mid_after_busy", c, busy, 1'b0);
        end

        // beeps=0 request, and stop+trig together in IDLE: nothing happens
        trig = 1'b1; beeps = 3'd0;
        tick();
        trig = 1'b1; beeps = 3'd2; stop = 1'b1;
        tick();
        trig = 1'b0; stop = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            chk("quiet_busy", c, busy, 1'b0);
            chk("quiet_buzz", c, buzz, 1'b0);
            chk("quiet_done", c, done, 1'b0);
            tick();
        end

        // stop alone in IDLE leaves a following request unaffected
        stop = 1'b1;
        tick();
        stop = 1'b0; trig = 1'b1; beeps = 3'd1;
        tick();
        trig = 1'b0;
        chk("idle_stop_then_trig_busy", 1, busy, 1'b1);
        chk("idle_stop_then_trig_buzz", 1, buzz, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buzzer_driver.md
BUZZER_DRIVER -- requirements
Module: buzzer_driver

Interface
REQ-001 SHALL have parameter TONE_HALF, default 12500, meaning buzz half-period in clk cycles (2 kHz at 50 MHz).
REQ-002 SHALL have parameter BEEP_CYC, default 5000000, meaning tone-on length per beep in clk cycles (100 ms).
REQ-003 SHALL have parameter GAP_CYC, default 5000000, meaning silent gap between beeps in clk cycles.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port trig  input  1  one-cycle request pulse, as produced by the key debouncer's press pulse.
REQ-007 SHALL have port beeps  input  3  beep count, sampled only on an accepted trig; 0 means the request is ignored.
REQ-008 SHALL have port stop  input  1  abort current playback.
REQ-009 SHALL have port buzz  output  1  square-wave drive to the buzzer.
REQ-010 SHALL have port busy  output  1  high while a sequence plays.
REQ-011 SHALL have port done  output  1  one-cycle pulse at sequence completion or abort.

Function
REQ-012 SHALL implement FSM states IDLE, TONE, GAP.
REQ-013 IDLE: trig=1 with beeps!=0 at edge T -> state TONE at T+1, buzz=1, remaining=beeps-1; tone and duration counters cleared.
REQ-014 TONE: buzz SHALL toggle every TONE_HALF cycles; state SHALL last exactly BEEP_CYC cycles.
REQ-015 TONE end with remaining>0 -> GAP with buzz=0 and remaining decremented; with remaining=0 -> IDLE with done=1 for that one cycle.
REQ-016 GAP SHALL last exactly GAP_CYC cycles with buzz=0, then return to TONE with buzz=1 and the tone counter cleared.
REQ-017 busy SHALL be 1 exactly in TONE and GAP; buzz SHALL be 0 in IDLE and GAP.
REQ-018 stop=1 in TONE or GAP -> IDLE next cycle, buzz=0, done=1 for one cycle, pending request cleared; stop in IDLE SHALL have no effect.
REQ-019 stop and trig in the same cycle: stop wins, trig discarded.
REQ-020 Counters SHALL be sized with $clog2 of their parameters and SHALL never wrap.
REQ-021 trig with beeps=0 SHALL change no state and SHALL not assert done.

Reset
REQ-022 rst=1 at an edge -> state IDLE, buzz=0, busy=0, done=0, all counters, remaining and the pending slot cleared; rst overrides stop and trig.
REQ-023 Reset asserted mid-sequence SHALL silence buzz on the following cycle with no done pulse.

Configuration
REQ-024 Macro BUZZER_PENDING_EN SHALL control request queuing.
REQ-025 With BUZZER_PENDING_EN defined: a trig (beeps!=0) accepted while busy SHALL be stored in a one-deep slot, a newer trig overwriting it; on completion the stored request SHALL start in TONE on the cycle after done with no IDLE dwell.
REQ-026 Without BUZZER_PENDING_EN: a trig while busy SHALL be dropped.

Structure
REQ-027 FSM state enum and default timing constants SHALL live in shared package alarm_pkg.
REQ-028 Tone generation SHALL be sub-module tone_gen (enable and half-period count in, square wave out); sequencing stays in buzzer_driver.

Verification (TONE_HALF=2, BEEP_CYC=8, GAP_CYC=4)
REQ-029 trig with beeps=1 at cycle 0 -> buzz 1,1,0,0,1,1,0,0 over cycles 1-8; done=1 at cycle 9; busy=1 for cycles 1-8.
REQ-030 trig with beeps=3 -> tone/gap/tone/gap/tone = 8/4/8/4/8 cycles; exactly one done pulse, at cycle 33.
REQ-031 stop at cycle 5 during beeps=2 -> buzz=0, busy=0 and done=1 at cycle 6, then silence.
REQ-032 BUZZER_PENDING_EN defined: beeps=1 trig at cycle 0, second beeps=1 trig at cycle 3 -> first sequence done at cycle 9, second TONE cycles 10-17; macro undefined -> silence after cycle 8.
REQ-033 rst at cycle 4 mid-tone -> buzz=0, busy=0 at cycle 5, no done; trig with beeps=0 -> no activity.
